// File: rtl/aes_pkg.sv
// Shared AES datapath definitions.
//   - xtime / gf_mul2 / gf_mul3: GF(2^8) helpers, polynomial 0x11B.
//   - MIX_FWD / MIX_INV: mode encodings for the column mixer.
//   - mix_state_e: FSM encoding of the iterative MixColumns engine.
package aes_pkg;

  localparam logic MIX_FWD = 1'b0;
  localparam logic MIX_INV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mix_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

endpackage

// File: rtl/mix_col.sv
// Combinational mixer for one 32-bit AES column.
//   col_in  : column, byte r at bits [31-8r -: 8]
//   inv     : MIX_INV selects InvMixColumns (honoured only when INV_EN=1)
//   col_out : mixed column, same layout
// InvMixColumns is the forward mix preceded by a cheap preprocess, so the
// inverse costs only two doubled-doubled XOR terms on top of the forward mix.
module mix_col
  import aes_pkg::*;
#(
  parameter int INV_EN = 1
) (
  input  logic [31:0] col_in,
  input  logic        inv,
  output logic [31:0] col_out
);

  logic       do_inv;
  logic [7:0] a0, a1, a2, a3;
  logic [7:0] p0, p1, p2, p3;
  logic [7:0] u, v;

  // With INV_EN=0 this is constant 0 and the preprocess is trimmed away.
  assign do_inv = (INV_EN != 0) && (inv == MIX_INV);

  // NOTE: every signal assigned in this always_comb gets a value on every
  // path (defaults first), otherwise synthesis would infer a latch.
  always_comb begin
    a0 = col_in[31:24];
    a1 = col_in[23:16];
    a2 = col_in[15:8];
    a3 = col_in[7:0];
    u  = xtime(xtime(a0 ^ a2));
    v  = xtime(xtime(a1 ^ a3));
    p0 = a0;
    p1 = a1;
    p2 = a2;
    p3 = a3;
    if (do_inv) begin
      p0 = a0 ^ u;
      p1 = a1 ^ v;
      p2 = a2 ^ u;
      p3 = a3 ^ v;
    end
    col_out = {gf_mul2(p0) ^ gf_mul3(p1) ^ p2 ^ p3,
               p0 ^ gf_mul2(p1) ^ gf_mul3(p2) ^ p3,
               p0 ^ p1 ^ gf_mul2(p2) ^ gf_mul3(p3),
               gf_mul3(p0) ^ p1 ^ p2 ^ gf_mul2(p3)};
  end

endmodule

// File: rtl/mixcolumns_iter.sv
// Iterative AES MixColumns / InvMixColumns engine.
// A 128-bit state is accepted over in_valid/in_ready, mixed COLS_PER_CYCLE
// columns per clock in place in a work register, and presented on
// out_valid/out_ready until taken.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake; in_data state, in_mode 0=fwd 1=inv
//   out_valid/out_ready : output handshake; out_data mixed state
// Column c of a state lives at bits [127-32c -: 32].
module mixcolumns_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1,
  parameter int INV_EN         = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int N     = 4 / COLS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  mix_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             mode_q;
  logic [31:0]      work_q [4];
  logic             accept;
  logic             last_grp;

  logic [1:0]  sel      [COLS_PER_CYCLE];
  logic [31:0] lane_in  [COLS_PER_CYCLE];
  logic [31:0] lane_out [COLS_PER_CYCLE];

  // in_ready looks at out_ready only in DONE, so a drained result and a new
  // state can swap on the same edge.
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign last_grp  = (cnt_q == CNT_W'(N - 1));
  assign out_data  = {work_q[0], work_q[1], work_q[2], work_q[3]};

  // Lane g of group cnt works on column cnt*COLS_PER_CYCLE + g.
  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_lane
    assign sel[g]     = 2'(int'(cnt_q) * COLS_PER_CYCLE + g);
    assign lane_in[g] = work_q[sel[g]];

    mix_col #(
      .INV_EN (INV_EN)
    ) u_mix_col (
      .col_in  (lane_in[g]),
      .inv     (mode_q),
      .col_out (lane_out[g])
    );
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (last_grp) state_d = DONE;
      DONE: begin
        if (accept)         state_d = BUSY;
        else if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      mode_q <= MIX_FWD;
      // NOTE: the work register is reset on purpose: it drives out_data
      // directly and must read as zero straight after reset.
      for (int i = 0; i < 4; i++) work_q[i] <= '0;
    end else if (accept) begin
      cnt_q     <= '0;
      mode_q    <= (INV_EN != 0) ? in_mode : MIX_FWD;
      work_q[0] <= in_data[127:96];
      work_q[1] <= in_data[95:64];
      work_q[2] <= in_data[63:32];
      work_q[3] <= in_data[31:0];
    end else if (state_q == BUSY) begin
      for (int g = 0; g < COLS_PER_CYCLE; g++) work_q[sel[g]] <= lane_out[g];
      cnt_q <= last_grp ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mixcolumns_iter.sv
// Self-checking bench for mixcolumns_iter. Four instances cover
// COLS_PER_CYCLE = 1, 2, 4 with InvMixColumns, and COLS_PER_CYCLE = 1 forward
// only. Expected states come from vector constants or from an independent
// matrix-multiply model, queued on accept and compared when each result
// leaves the DUT.
module tb_mixcolumns_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [127:0] in_data;
  logic         in_mode;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [127:0] out_data [4];

  always #5 clk = ~clk;

  for (genvar i = 0; i < 4; i++) begin : g_dut
    localparam int CPC = (i == 0) ? 1 : (i == 1) ? 2 : (i == 2) ? 4 : 1;
    localparam int INV = (i == 3) ? 0 : 1;
    mixcolumns_iter #(
      .COLS_PER_CYCLE (CPC),
      .INV_EN         (INV)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[i]),
      .in_ready  (in_ready[i]),
      .in_data   (in_data),
      .in_mode   (in_mode),
      .out_valid (out_valid[i]),
      .out_ready (out_ready[i]),
      .out_data  (out_data[i])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;
  int rx_count = 0;
  logic [127:0] exp_q [$];

  typedef struct {
    logic [127:0] data;
    logic         mode;
    logic [127:0] exp_inv;    // expected with InvMixColumns built in
    logic [127:0] exp_noinv;  // expected with forward-only build
  } vec_t;

  vec_t vecs [5];

  function automatic int n_of(input int d);
    return (d == 1) ? 2 : (d == 2) ? 1 : 4;
  endfunction

  function automatic bit inv_of(input int d);
    return d != 3;
  endfunction

  // Reference model: plain GF(2^8) matrix multiply with the FIPS-197 matrices.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [31:0] ref_col(input logic [31:0] c, input logic inv);
    logic [7:0]  k [4];
    logic [7:0]  a [4];
    logic [31:0] r = '0;
    if (inv) begin
      k[0] = 8'h0e; k[1] = 8'h0b; k[2] = 8'h0d; k[3] = 8'h09;
    end else begin
      k[0] = 8'h02; k[1] = 8'h03; k[2] = 8'h01; k[3] = 8'h01;
    end
    for (int j = 0; j < 4; j++) a[j] = c[31-8*j -: 8];
    for (int rr = 0; rr < 4; rr++) begin
      logic [7:0] s;
      s = 8'h00;
      for (int j = 0; j < 4; j++) s = s ^ gmul(k[(j - rr + 4) % 4], a[j]);
      r[31-8*rr -: 8] = s;
    end
    return r;
  endfunction

  function automatic logic [127:0] ref_state(input logic [127:0] d, input logic mode,
                                             input bit inv_en);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = ref_col(d[127-32*c -: 32], inv_en && mode);
    return o;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one state on DUT d, hold it until accepted, queue its expectation.
  // Returns #1 after the accepting edge.
  task automatic send(input int d, input logic [127:0] data, input logic mode,
                      input logic [127:0] exp);
    bit ok = 0;
    in_valid[d] = 1'b1;
    in_data     = data;
    in_mode     = mode;
    for (int guard = 0; guard < 200 && !ok; guard++) begin
      @(negedge clk);
      if (in_ready[d]) ok = 1;
      @(posedge clk);
      if (ok) exp_q.push_back(exp);
    end
    #1;
    in_valid[d] = 1'b0;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept timeout d%0d", d);
    end
  endtask

  // Count edges from the accept until out_valid rises (bounded).
  task automatic wait_valid(input int d, output int lat);
    lat = 0;
    while (!out_valid[d] && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic [127:0] a_exp, b_exp, junk;

    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = '1;
    in_data   = '0;
    in_mode   = 1'b0;

    vecs[0] = '{128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0,
                128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6,
                128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
    vecs[1] = '{128'h00000000_00000000_00000000_00000001, 1'b0,
                128'h00000000_00000000_00000000_01010302,
                128'h00000000_00000000_00000000_01010302};
    vecs[2] = '{128'hd4d4d4d5_2d26314c_00000000_11111111, 1'b0,
                128'hd5d5d7d6_4d7ebdf8_00000000_11111111,
                128'hd5d5d7d6_4d7ebdf8_00000000_11111111};
    vecs[3] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1,
                128'hdb135345_f20a225c_01010101_c6c6c6c6,
                ref_state(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b0, 0)};
    vecs[4] = '{128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b1,
                ref_state(128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b1, 1),
                128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};

    fork
      begin : watchdog
        #1_000_000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
      end
      begin : monitor
        forever begin
          @(negedge clk);
          for (int d = 0; d < 4; d++) begin
            if (rst_n && out_valid[d] && out_ready[d]) begin
              rx_count++;
              if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected output d%0d: got %h expected none", d, out_data[d]);
              end else begin
                check($sformatf("out d%0d", d), out_data[d], exp_q.pop_front());
              end
            end
          end
        end
      end
    join_none

    // Reset state.
    #2;
    for (int d = 0; d < 4; d++) begin
      check($sformatf("rst out_valid d%0d", d), 128'(out_valid[d]), 128'd0);
      check($sformatf("rst out_data d%0d", d), out_data[d], 128'd0);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    for (int d = 0; d < 4; d++) check($sformatf("rst in_ready d%0d", d), 128'(in_ready[d]), 128'd1);

    // Vector table on every configuration, with latency.
    for (int d = 0; d < 4; d++) begin
      for (int v = 0; v < 5; v++) begin
        send(d, vecs[v].data, vecs[v].mode, inv_of(d) ? vecs[v].exp_inv : vecs[v].exp_noinv);
        wait_valid(d, lat);
        check($sformatf("latency d%0d v%0d", d, v), 128'(lat), 128'(n_of(d)));
        @(posedge clk);
        #1;
      end
    end

    // Backpressure on the COLS_PER_CYCLE=1 instance.
    out_ready[0] = 1'b0;
    a_exp = vecs[0].exp_inv;
    send(0, vecs[0].data, 1'b0, a_exp);
    wait_valid(0, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold out_data", out_data[0], a_exp);
      check("hold out_valid", 128'(out_valid[0]), 128'd1);
      check("hold in_ready", 128'(in_ready[0]), 128'd0);
    end
    @(posedge clk);
    #1;
    out_ready[0] = 1'b1;
    b_exp = vecs[2].exp_inv;
    send(0, vecs[2].data, 1'b0, b_exp);
    wait_valid(0, lat);
    check("swap latency", 128'(lat), 128'd4);
    @(posedge clk);
    #1;

    // Inputs changing while busy are ignored.
    send(0, vecs[1].data, 1'b0, vecs[1].exp_inv);
    in_valid[0] = 1'b1;
    in_data     = 128'hffeeddcc_bbaa9988_77665544_33221100;
    in_mode     = 1'b1;
    @(negedge clk);
    check("busy in_ready", 128'(in_ready[0]), 128'd0);
    @(posedge clk);
    #1 in_data = 128'h01234567_89abcdef_fedcba98_76543210;
    @(negedge clk);
    check("busy in_ready 2", 128'(in_ready[0]), 128'd0);
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    in_mode = 1'b0;
    wait_valid(0, lat);
    @(posedge clk);
    #1;

    // Asynchronous reset while BUSY with cnt=1.
    junk = ref_state(vecs[2].data, 1'b0, 1);
    send(0, vecs[2].data, 1'b0, junk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst out_valid", 128'(out_valid[0]), 128'd0);
    check("midrst out_data", out_data[0], 128'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("postrst in_ready", 128'(in_ready[0]), 128'd1);
    @(posedge clk);
    #1;
    send(0, vecs[0].data, 1'b0, vecs[0].exp_inv);
    wait_valid(0, lat);
    check("postrst latency", 128'(lat), 128'd4);
    @(posedge clk);
    #1;

    // Random handshakes, 1000 states against the model.
    rx_count = 0;
    fork
      begin : producer
        for (int i = 0; i < 1000; i++) begin
          logic [31:0]  w0, w1, w2, w3;
          logic [127:0] st;
          logic         md;
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          w0 = $urandom(); w1 = $urandom(); w2 = $urandom(); w3 = $urandom();
          st = {w0, w1, w2, w3};
          md = 1'($urandom_range(0, 1));
          send(0, st, md, ref_state(st, md, 1));
        end
      end
      begin : consumer
        for (int guard = 0; guard < 40000 && rx_count < 1000; guard++) begin
          @(posedge clk);
          #1 out_ready[0] = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready[0] = 1'b1;
    repeat (3) @(posedge clk);
    check("random received", 128'(rx_count), 128'd1000);
    check("scoreboard empty", 128'(exp_q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mixcolumns_iter.md
# mixcolumns_iter

Sequential, parametrised MixColumns engine for the AES datapath. It accepts a 128-bit state over a valid/ready handshake and applies either forward MixColumns (encrypt) or InvMixColumns (decrypt). It processes COLS_PER_CYCLE columns per clock and returns the result over a second valid/ready handshake. It sits between ShiftRows/InvShiftRows and AddRoundKey in the round pipeline, and replaces the single-cycle combinational column mixer.

## Interface
Parameters:
- COLS_PER_CYCLE, 1, number of columns mixed per clock; legal values are 1, 2, 4.
- INV_EN, 1, 1 instantiates InvMixColumns support; 0 builds forward only and ignores mode.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  in_data and in_mode are valid.
- in_ready  out  1  block can accept a state this cycle.
- in_data  in  128  state; column c = bits [127-32c -: 32]; byte r of a column = bits [31-8r -: 8] (FIPS-197 order).
- in_mode  in  1  0 = forward MixColumns, 1 = InvMixColumns.
- out_valid  out  1  out_data holds a completed result.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  128  mixed state, same byte layout as in_data.

## Operation
- States: IDLE, BUSY, DONE. Let N = 4/COLS_PER_CYCLE.
- Accept: a transfer occurs when in_valid && in_ready on a rising edge. in_data goes to a 128-bit work register, in_mode to a mode register (forced to 0 when INV_EN=0), and the group counter is cleared.
- IDLE: in_ready=1. An accept moves to BUSY.
- BUSY: each cycle, columns [cnt*COLS_PER_CYCLE, cnt*COLS_PER_CYCLE+COLS_PER_CYCLE-1] of the work register are replaced in place with their mixed value, and cnt increments. When the last group is written, move to DONE. cnt width is clog2(N), minimum 1.
- DONE: out_valid=1, out_data = work register, held stable until out_ready.
- in_ready = (state==IDLE) || (state==DONE && out_ready). A simultaneous output handshake and input accept in DONE goes directly to BUSY with the new state. Back-to-back throughput is one state per N cycles.
- DONE with out_ready and no accept: go to IDLE.
- in_valid while BUSY: ignored. Upstream holds the state until in_ready.
- Arithmetic is in GF(2^8) with polynomial 0x11B. xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1B : 8'h00).
- Forward column mixing: b0=2a0^3a1^a2^a3, b1=a0^2a1^3a2^a3, b2=a0^a1^2a2^3a3, b3=3a0^a1^a2^2a3.
- Inverse column mixing is a preprocess followed by the forward mix:
  - u = xtime(xtime(a0^a2)), v = xtime(xtime(a1^a3)).
  - a0^=u, a1^=v, a2^=u, a3^=v.
  - Then apply the forward mix.
- Reset (any time, including mid-BUSY or DONE):
  - state=IDLE, cnt=0, work register=0, mode=0.
  - out_valid=0, out_data=0, in_ready=1 once rst_n is released.
  - Any in-flight state is discarded.

## Timing
- Latency: accept on edge k gives out_valid=1 after edge k+N, i.e. 1 cycle for COLS_PER_CYCLE=4 and 4 cycles for COLS_PER_CYCLE=1.
- out_valid, in_ready and out_data are registered or decoded from registered state only. There is no combinational path from in_data to out_data.
- in_ready depends combinationally on out_ready in DONE only.
- Mode is sampled once, at accept. Changes to in_mode during BUSY have no effect.

## Structure
- Package aes_pkg holds:
  - the xtime function;
  - gf_mul2 and gf_mul3 functions;
  - the mode constants MIX_FWD=1'b0 and MIX_INV=1'b1;
  - the FSM state encoding.
- Sub-module mix_col: combinational, 32-bit column in, inv input, 32-bit column out. It contains the inverse preprocess when INV_EN=1. It is instantiated COLS_PER_CYCLE times via generate; the top module holds only FSM, counter and registers.

## Test plan
- Forward FIPS-197 columns, all COLS_PER_CYCLE values: in_data = db135345_f20a225c_01010101_c6c6c6c6, mode 0 -> out_data = 8e4da1bc_9fdc589d_01010101_c6c6c6c6, out_valid exactly N cycles after accept.
- Single-byte column: in_data = 00000000_00000000_00000000_00000001, mode 0 -> 00000000_00000000_00000000_01010302. Columns d4d4d4d5_2d26314c_00000000_11111111 -> d5d5d7d6_4d7ebdf8_00000000_11111111.
- Inverse round-trip: feed the result of the first scenario with mode 1 -> original db135345_f20a225c_01010101_c6c6c6c6. With INV_EN=0 and mode 1 -> forward result.
- Backpressure:
  - hold out_ready=0 for 5 cycles in DONE -> out_data stable, in_ready=0;
  - then out_ready=1 with in_valid=1 -> output and input transfer on the same edge, next result after N cycles;
  - random in_valid/out_ready over 1000 states -> no loss or duplication, matched against a reference model.
- Reset mid-operation: assert rst_n=0 asynchronously during BUSY cnt=1 -> out_valid=0, out_data=0 immediately; after release, in_ready=1 and the next state is processed correctly.
- Ignore while busy: change in_data and in_mode during BUSY -> result reflects only the accepted state and mode.
